// File: rtl/spi_txn_sequencer.sv
// spi_txn_sequencer: command FIFO plus transaction sequencer in front of the
// 3-slave SPI top. Each command drives CS/RW/MODE/WDATA for a fixed window,
// then the read-back byte is returned on a valid/ready response channel.
// Optional build macro SPI_SEQ_TXN_COUNT_EN adds a 16-bit txn_count output
// counting successful (rsp_err=0) response handshakes.
module spi_txn_sequencer #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned XFER_CYCLES = 18,
    parameter int unsigned IDLE_GAP    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [13:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_data,
    output logic [1:0]  rsp_cs,
    output logic        rsp_err,
    output logic [1:0]  spi_cs,
    output logic [1:0]  spi_rw,
    output logic [1:0]  spi_mode,
    output logic [7:0]  spi_wdata,
    input  logic [7:0]  spi_rdata,
`ifdef SPI_SEQ_TXN_COUNT_EN
    output logic        busy,
    output logic [15:0] txn_count
`else
    output logic        busy
`endif
);

    localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OCC_W   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CNT_MAX = (XFER_CYCLES > IDLE_GAP) ? XFER_CYCLES : IDLE_GAP;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef struct packed {
        logic [1:0] cs;
        logic [1:0] rw;
        logic [1:0] mode;
        logic [7:0] wdata;
    } cmd_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        XFER  = 3'd2,
        RESP  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    cmd_t              cmd_q, cmd_d;
    cmd_t              mem [FIFO_DEPTH];
    cmd_t              head;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic              push, pop;

    logic              rsp_valid_d, rsp_err_d, cmd_ready_d, busy_d;
    logic [7:0]        rsp_data_d, spi_wdata_d;
    logic [1:0]        rsp_cs_d, spi_cs_d, spi_rw_d, spi_mode_d;

    assign head = mem[rd_ptr];
    assign push = cmd_valid & cmd_ready;

    // FIFO storage and pointers; pointers wrap naturally at the power-of-2 depth
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // FIFO payload array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cmd_t'(cmd_data);
        end
    end

    // State, counters and all registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cmd_q     <= '0;
            occ_q     <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_cs    <= '0;
            rsp_err   <= 1'b0;
            spi_cs    <= '0;
            spi_rw    <= '0;
            spi_mode  <= '0;
            spi_wdata <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_q     <= cmd_d;
            occ_q     <= occ_d;
            cmd_ready <= cmd_ready_d;
            busy      <= busy_d;
            rsp_valid <= rsp_valid_d;
            rsp_data  <= rsp_data_d;
            rsp_cs    <= rsp_cs_d;
            rsp_err   <= rsp_err_d;
            spi_cs    <= spi_cs_d;
            spi_rw    <= spi_rw_d;
            spi_mode  <= spi_mode_d;
            spi_wdata <= spi_wdata_d;
        end
    end

    // Next-state, pop decision and next values of the registered outputs
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_d       = cmd_q;
        pop         = 1'b0;
        rsp_valid_d = rsp_valid;
        rsp_data_d  = rsp_data;
        rsp_cs_d    = rsp_cs;
        rsp_err_d   = rsp_err;
        spi_cs_d    = '0;
        spi_rw_d    = '0;
        spi_wdata_d = '0;
        spi_mode_d  = spi_mode;

        case (state_q)
            IDLE: begin
                if (occ_q != '0) begin
                    pop   = 1'b1;
                    cmd_d = head;
                    if (head.cs != 2'b00) begin
                        state_d = SETUP;
                    end else begin
                        // no slave addressed: answer immediately with an error
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = '0;
                        rsp_cs_d    = 2'b00;
                    end
                end
            end
            SETUP: begin
                state_d = XFER;
                cnt_d   = '0;
            end
            XFER: begin
                if (cnt_q == CNT_W'(XFER_CYCLES - 1)) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = spi_rdata;
                    rsp_cs_d    = cmd_q.cs;
                    rsp_err_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = GAP;
                    cnt_d       = '0;
                end
            end
            GAP: begin
                if (cnt_q == CNT_W'(IDLE_GAP - 1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // SPI fields are live only while the transaction window is open
        if ((state_d == SETUP) || (state_d == XFER)) begin
            spi_cs_d    = cmd_d.cs;
            spi_rw_d    = cmd_d.rw;
            spi_mode_d  = cmd_d.mode;
            spi_wdata_d = cmd_d.wdata;
        end
    end

    // Occupancy bookkeeping; simultaneous push and pop leave it unchanged
    always_comb begin
        occ_d = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
        cmd_ready_d = (occ_d != OCC_W'(FIFO_DEPTH));
        busy_d      = (state_d != IDLE) || (occ_d != '0);
    end

`ifdef SPI_SEQ_TXN_COUNT_EN
    // Count successful response handshakes, wrapping at 16 bits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            txn_count <= '0;
        end else if ((state_q == RESP) && rsp_ready && !rsp_err) begin
            txn_count <= txn_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_spi_txn_sequencer.sv
// Directed self-checking bench for spi_txn_sequencer (default parameters).
module tb_spi_txn_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [13:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;
    logic [1:0]  rsp_cs;
    logic        rsp_err;
    logic [1:0]  spi_cs;
    logic [1:0]  spi_rw;
    logic [1:0]  spi_mode;
    logic [7:0]  spi_wdata;
    logic [7:0]  spi_rdata;
    logic        busy;
`ifdef SPI_SEQ_TXN_COUNT_EN
    logic [15:0] txn_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    spi_txn_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_cs    (rsp_cs),
        .rsp_err   (rsp_err),
        .spi_cs    (spi_cs),
        .spi_rw    (spi_rw),
        .spi_mode  (spi_mode),
        .spi_wdata (spi_wdata),
        .spi_rdata (spi_rdata),
`ifdef SPI_SEQ_TXN_COUNT_EN
        .busy      (busy),
        .txn_count (txn_count)
`else
        .busy      (busy)
`endif
    );

    always #5 clk = ~clk;

    // compare, count and report
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // advance one clock; sample point is 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [13:0] mk(input logic [1:0] cs, input logic [1:0] rw,
                                       input logic [1:0] mode, input logic [7:0] wd);
        return {cs, rw, mode, wd};
    endfunction

    // wait for rsp_valid within a cycle budget; a timeout is a failed check
    task automatic wait_rsp(input string tag, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check(tag, 32'(ok), 32'd1);
    endtask

    // consume the current response, then let the gap elapse back to idle
    task automatic handshake_and_gap();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        tick();
        tick();
    endtask

    logic [1:0]  fill_cs [5];
    int          stable, acc, first_k;
    bit          flag;
    logic [7:0]  hold_data;
    logic [1:0]  hold_cs;

    initial begin
        fill_cs[0] = 2'b01; fill_cs[1] = 2'b10; fill_cs[2] = 2'b11;
        fill_cs[3] = 2'b01; fill_cs[4] = 2'b10;

        reset = 1'b1; cmd_valid = 1'b0; cmd_data = '0;
        rsp_ready = 1'b0; spi_rdata = 8'h00;
        tick(); tick(); tick();

        // reset state
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data",  32'(rsp_data),  32'd0);
        check("rst_rsp_cs_err", 32'({rsp_cs, rsp_err}), 32'd0);
        check("rst_spi", 32'({spi_cs, spi_rw, spi_mode, spi_wdata}), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        reset = 1'b0;
        tick();

        // single write, 19-cycle window, read-back sampled on last XFER cycle
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_data  = mk(2'b01, 2'b10, 2'b00, 8'hA5);
        tick();                                    // E0
        cmd_valid = 1'b0;
        check("sw_busy_e0",  32'(busy),   32'd1);
        check("sw_cs_e0",    32'(spi_cs), 32'd0);
        stable = 0;
        for (int i = 1; i <= 20; i++) begin
            spi_rdata = 8'h40 + 8'(i);
            tick();                                // E0+i
            if (i <= 19 && spi_cs == 2'b01 && spi_wdata == 8'hA5 && spi_rw == 2'b10) stable++;
            if (i == 19) check("sw_valid_e19", 32'(rsp_valid), 32'd0);
        end
        check("sw_stable_cycles", 32'(stable), 32'd19);
        check("sw_valid_e20", 32'(rsp_valid), 32'd1);
        check("sw_rsp_data",  32'(rsp_data),  32'h54);
        check("sw_rsp_cs_err", 32'({rsp_cs, rsp_err}), 32'({2'b01, 1'b0}));
        check("sw_spi_idle",  32'({spi_cs, spi_rw, spi_wdata}), 32'd0);
        tick();                                    // handshake
        check("sw_pulse", 32'(rsp_valid), 32'd0);
        tick();
        check("sw_busy_gap", 32'(busy), 32'd1);
        tick();
        check("sw_busy_idle", 32'(busy), 32'd0);
        rsp_ready = 1'b0;

        // cs=00 command: error response, no SPI activity
        cmd_valid = 1'b1;
        cmd_data  = mk(2'b00, 2'b01, 2'b01, 8'h77);
        tick();                                    // E0
        cmd_valid = 1'b0;
        check("err_early", 32'(rsp_valid), 32'd0);
        tick();                                    // E0+1
        check("err_rsp", 32'({rsp_valid, rsp_err, rsp_data}), 32'({1'b1, 1'b1, 8'h00}));
        check("err_spi_cs", 32'(spi_cs), 32'd0);
        handshake_and_gap();
        check("err_done", 32'({rsp_valid, busy}), 32'd0);

        // backpressure with a queued second command
        spi_rdata = 8'hC3;
        cmd_valid = 1'b1;
        cmd_data  = mk(2'b10, 2'b01, 2'b11, 8'h5A);
        tick();
        cmd_data  = mk(2'b11, 2'b00, 2'b11, 8'h3C);
        tick();
        cmd_valid = 1'b0;
        wait_rsp("bp_a_timeout", 40);
        hold_data = rsp_data;
        hold_cs   = rsp_cs;
        check("bp_a_data", 32'(rsp_data), 32'hC3);
        check("bp_a_cs",   32'(rsp_cs),   32'd2);
        flag = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!rsp_valid || rsp_data != hold_data || rsp_cs != hold_cs || spi_cs != 2'b00) flag = 1'b0;
        end
        check("bp_stable", 32'(flag), 32'd1);
        check("bp_mode_hold", 32'(spi_mode), 32'd3);
        rsp_ready = 1'b1;
        tick();                                    // handshake H
        rsp_ready = 1'b0;
        first_k = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (first_k == 0 && spi_cs != 2'b00) first_k = k;
        end
        check("bp_setup_delay", 32'(first_k), 32'd3);
        wait_rsp("bp_b_timeout", 40);
        check("bp_b_cs", 32'(rsp_cs), 32'd3);
        handshake_and_gap();

        // fill the FIFO with responses stalled, then drain in order
        acc = 0;
        for (int i = 0; i < 10 && acc < 5; i++) begin
            cmd_valid = 1'b1;
            cmd_data  = mk(fill_cs[acc], 2'b01, 2'b00, 8'(acc));
            flag = cmd_ready;
            tick();
            if (flag) acc++;
        end
        check("fill_accepts", 32'(acc), 32'd5);
        check("fill_full", 32'(cmd_ready), 32'd0);
        cmd_data = mk(2'b11, 2'b11, 2'b00, 8'hEE);
        flag = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (cmd_ready) flag = 1'b0;
        end
        check("fill_no_6th", 32'(flag), 32'd1);
        cmd_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            wait_rsp("fill_timeout", 60);
            check($sformatf("fill_order%0d", k), 32'(rsp_cs), 32'(fill_cs[k]));
            handshake_and_gap();
        end
        flag = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (rsp_valid) flag = 1'b0;
        end
        check("fill_drained", 32'({flag, busy}), 32'({1'b1, 1'b0}));

        // reset during XFER with three commands queued
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cmd_valid = 1'b1;
            cmd_data  = mk(2'b01, 2'b00, 2'b00, 8'(8'h10 + 8'(i)));
            tick();
        end
        cmd_valid = 1'b0;
        tick(); tick(); tick();
        check("rstx_in_xfer", 32'(spi_cs), 32'd1);
        #3 reset = 1'b1;
        #1;
        check("rstx_now", 32'({spi_cs, rsp_valid, busy, cmd_ready}), 32'({2'b00, 1'b0, 1'b0, 1'b1}));
`ifdef SPI_SEQ_TXN_COUNT_EN
        check("rstx_cnt", 32'(txn_count), 32'd0);
`endif
        tick();
        reset = 1'b0;
        flag = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (rsp_valid || spi_cs != 2'b00 || busy) flag = 1'b0;
        end
        check("rstx_quiet", 32'(flag), 32'd1);

`ifdef SPI_SEQ_TXN_COUNT_EN
        // three good and one error command
        for (int k = 0; k < 4; k++) begin
            cmd_valid = 1'b1;
            cmd_data  = mk((k == 2) ? 2'b00 : 2'b10, 2'b00, 2'b00, 8'(k));
            tick();
            cmd_valid = 1'b0;
            wait_rsp("cnt_timeout", 40);
            handshake_and_gap();
        end
        check("cnt_three", 32'(txn_count), 32'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
